// File: rtl/mac_stream_engine.sv
// Stream datapath of the MAC accelerator: joins a/b operands through a product stage,
// then either accumulates them (scalar product, plus c on drain) or emits shifted products on d.
package mac_package;
    localparam int unsigned MAC_CNT_LEN = 1024;
    localparam int unsigned CW = $clog2(MAC_CNT_LEN) + 1;

    typedef struct packed {
        logic          clear;
        logic          enable;
        logic          simple_mul;
        logic          start;
        logic [4:0]    shift;
        logic [CW-1:0] len;
    } ctrl_engine_t;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          acc_done;
    } flags_engine_t;
endpackage

module mac_stream_engine #(
    parameter int unsigned MAC_CNT_LEN = mac_package::MAC_CNT_LEN
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  mac_package::ctrl_engine_t    ctrl_i,
    output mac_package::flags_engine_t   flags_o,
    input  logic [31:0]                  a_data_i,
    input  logic [31:0]                  b_data_i,
    input  logic [31:0]                  c_data_i,
    input  logic                         a_valid_i,
    input  logic                         b_valid_i,
    input  logic                         c_valid_i,
    output logic                         a_ready_o,
    output logic                         b_ready_o,
    output logic                         c_ready_o,
    output logic [31:0]                  d_data_o,
    output logic                         d_valid_o,
    input  logic                         d_ready_i
);
    localparam int unsigned CW = $clog2(MAC_CNT_LEN) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;
    state_t state_q, state_d;

    logic               sm_q;
    logic [4:0]         shift_q;
    logic [CW-1:0]      len_q, cnt_q, icnt_q, cnt_inc;
    logic [63:0]        acc_q, p_q;
    logic               p_v_q, d_v_q, done_q, done_d, c_done_q;
    logic [31:0]        d_q, d_next;
    logic               run, d_take, p_take, ab_take, c_take, d_load;
    logic signed [63:0] prod, acc_sh, p_sh;

    assign run     = ctrl_i.enable & ~ctrl_i.clear;
    assign d_take  = run & d_v_q & d_ready_i;
    // Stage P drains into the accumulator every cycle; in simple-mul it needs room in d.
    assign p_take  = run & (state_q == ACCUM) & p_v_q & (~sm_q | ~d_v_q | d_take);
    assign ab_take = run & (state_q == ACCUM) & a_valid_i & b_valid_i
                   & (icnt_q < len_q) & (~p_v_q | p_take);
    assign c_take  = run & (state_q == DRAIN) & ~c_done_q & c_valid_i & ~d_v_q;
    assign d_load  = c_take | (p_take & sm_q);
    assign cnt_inc = cnt_q + 1'b1;

    assign prod   = $signed(a_data_i) * $signed(b_data_i);
    assign acc_sh = $signed(acc_q) >>> shift_q;
    assign p_sh   = $signed(p_q) >>> shift_q;
    assign d_next = c_take ? (c_data_i + acc_sh[31:0]) : p_sh[31:0];

    assign a_ready_o        = ab_take;
    assign b_ready_o        = ab_take;
    assign c_ready_o        = c_take;
    assign d_data_o         = d_q;
    assign d_valid_o        = d_v_q;
    assign flags_o.cnt      = cnt_q;
    assign flags_o.acc_done = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               state_q <= IDLE;
        else if (ctrl_i.clear)     state_q <= IDLE;
        else if (ctrl_i.enable)    state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run && ctrl_i.start) begin
                    if (ctrl_i.len == '0) done_d  = 1'b1;
                    else                  state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (p_take && (cnt_inc == len_q)) begin
                    done_d  = 1'b1;
                    state_d = sm_q ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (c_done_q && d_take) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || ctrl_i.clear) begin
            sm_q     <= 1'b0;
            shift_q  <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            icnt_q   <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            p_v_q    <= 1'b0;
            d_q      <= '0;
            d_v_q    <= 1'b0;
            done_q   <= 1'b0;
            c_done_q <= 1'b0;
        end else if (ctrl_i.enable) begin
            done_q <= done_d;
            if (state_q == IDLE && ctrl_i.start) begin
                sm_q     <= ctrl_i.simple_mul;
                shift_q  <= ctrl_i.shift;
                len_q    <= ctrl_i.len;
                acc_q    <= '0;
                cnt_q    <= '0;
                icnt_q   <= '0;
                c_done_q <= 1'b0;
            end
            if (ab_take) begin
                p_q    <= prod;
                icnt_q <= icnt_q + 1'b1;
            end
            if (ab_take)     p_v_q <= 1'b1;
            else if (p_take) p_v_q <= 1'b0;
            if (p_take) begin
                cnt_q <= cnt_inc;
                if (!sm_q) acc_q <= acc_q + p_q;
            end
            if (d_load) begin
                d_q   <= d_next;
                d_v_q <= 1'b1;
            end else if (d_take) begin
                d_v_q <= 1'b0;
            end
            if (c_take) c_done_q <= 1'b1;
        end
    end
endmodule
